// File: rtl/sma_crossover_engine.sv
// Fast/slow moving averages over a circular sample buffer, with a buy/sell crossover detector.
// Latency: results appear one edge after the sample is accepted. No backpressure: every valid sample is taken.
module sma_crossover_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int FAST_LOG2  = 2,
    parameter int SLOW_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic [DATA_WIDTH-1:0] fast_sma,
    output logic [DATA_WIDTH-1:0] slow_sma,
    output logic                  sma_valid,
    output logic                  warm,
    output logic [1:0]            trade_signal
);

    localparam int NF = 1 << FAST_LOG2;
    localparam int NS = 1 << SLOW_LOG2;
    localparam int FW = DATA_WIDTH + FAST_LOG2;
    localparam int SW = DATA_WIDTH + SLOW_LOG2;

    localparam logic [SLOW_LOG2-1:0] NF_OFS = SLOW_LOG2'(NF);
    localparam logic [SLOW_LOG2:0]   NS_CNT = (SLOW_LOG2+1)'(NS);
    localparam logic [SLOW_LOG2:0]   NF_CNT = (SLOW_LOG2+1)'(NF);

    localparam logic [1:0] TRADE_HOLD = 2'b00;
    localparam logic [1:0] TRADE_BUY  = 2'b01;
    localparam logic [1:0] TRADE_SELL = 2'b10;

    typedef enum logic [1:0] {
        REL_UNKNOWN = 2'd0,
        REL_ABOVE   = 2'd1,
        REL_BELOW   = 2'd2
    } rel_t;

    logic [DATA_WIDTH-1:0] buf_q [NS];
    logic [SLOW_LOG2-1:0]  wr_ptr_q;
    logic [SLOW_LOG2:0]    count_q;
    logic [FW-1:0]         fast_sum_q;
    logic [SW-1:0]         slow_sum_q;
    logic                  warm_q;
    logic                  pend_q;

    logic [DATA_WIDTH-1:0] fast_sma_q;
    logic [DATA_WIDTH-1:0] slow_sma_q;
    logic                  sma_valid_q;
    logic [1:0]            trade_q;
    rel_t                  rel_q;

    logic [SLOW_LOG2-1:0]  fast_idx;
    logic [FW-1:0]         fast_sub;
    logic [SW-1:0]         slow_sub;
    logic [FW-1:0]         fast_sum_nxt;
    logic [SW-1:0]         slow_sum_nxt;
    logic [SLOW_LOG2:0]    count_nxt;
    logic [DATA_WIDTH-1:0] fast_avg;
    logic [DATA_WIDTH-1:0] slow_avg;

    // The fast window's oldest sample sits NF slots behind the write pointer; the
    // slow window's oldest sample is the one about to be overwritten.
    always_comb begin
        fast_idx     = wr_ptr_q - NF_OFS;
        fast_sub     = (count_q >= NF_CNT) ? FW'(buf_q[fast_idx]) : '0;
        slow_sub     = warm_q ? SW'(buf_q[wr_ptr_q]) : '0;
        fast_sum_nxt = fast_sum_q + FW'(data_in) - fast_sub;
        slow_sum_nxt = slow_sum_q + SW'(data_in) - slow_sub;
        count_nxt    = (count_q == NS_CNT) ? count_q : count_q + 1'b1;
    end

    assign fast_avg = DATA_WIDTH'(fast_sum_q >> FAST_LOG2);
    assign slow_avg = DATA_WIDTH'(slow_sum_q >> SLOW_LOG2);

    // Stage 1: buffer write, running sums, fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fast_sum_q <= '0;
            slow_sum_q <= '0;
            warm_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (data_valid_in) begin
                buf_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                count_q         <= count_nxt;
                fast_sum_q      <= fast_sum_nxt;
                slow_sum_q      <= slow_sum_nxt;
                if (count_nxt == NS_CNT) begin
                    warm_q <= 1'b1;
                    pend_q <= 1'b1;
                end
            end
        end
    end

    // Stage 2: averages, relation tracking and crossover detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fast_sma_q  <= '0;
            slow_sma_q  <= '0;
            sma_valid_q <= 1'b0;
            trade_q     <= TRADE_HOLD;
            rel_q       <= REL_UNKNOWN;
        end else begin
            sma_valid_q <= pend_q;
            trade_q     <= TRADE_HOLD;
            if (pend_q) begin
                fast_sma_q <= fast_avg;
                slow_sma_q <= slow_avg;
                // Equal averages keep the previous relation so a touch is not a cross.
                if (fast_avg > slow_avg) begin
                    rel_q <= REL_ABOVE;
                    if (rel_q == REL_BELOW) begin
                        trade_q <= TRADE_BUY;
                    end
                end else if (fast_avg < slow_avg) begin
                    rel_q <= REL_BELOW;
                    if (rel_q == REL_ABOVE) begin
                        trade_q <= TRADE_SELL;
                    end
                end
            end
        end
    end

    assign fast_sma     = fast_sma_q;
    assign slow_sma     = slow_sma_q;
    assign sma_valid    = sma_valid_q;
    assign warm         = warm_q;
    assign trade_signal = trade_q;

endmodule
